sram_port_arbiter: RTL and testbench

- Two-requester front end for the 64x4 SRAM22 macro (sram22_64x4m4w2): round-robin arbitration, valid/ready request handshake, per-requester read-response return.
- Sits between two client blocks and one macro instance; drives macro pins directly, no extra input registering.
- Macro samples its inputs on the clock edge and presents read data the following cycle.

---
 rtl/sram_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Two-requester front end for the 64x4 SRAM22 macro (sram22_64x4m4w2).
//   Round-robin arbitration between req0 and req1, one grant per cycle,
//   macro pins driven combinationally from the granted request, read data
//   returned to the requester that issued the read one cycle after its grant.
//
//   Optional build macro: SRAM_ARB_SCRUB_EN
//     When defined, every reset is followed by a scrub pass that writes zero
//     to all RAM_DEPTH words before requests are accepted.
//
// Handshake: a request transfers in the cycle where reqN_valid && reqN_ready.
//   reqN_ready is a combinational function of both valids, the FSM state and
//   the round-robin pointer; it never depends on anything else. A requester
//   holds we/wmask/addr/din stable while valid and not ready. Read responses
//   (rspN_valid/rspN_rdata) have no backpressure.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   reqN_valid/ready        request handshake, N = 0,1
//   reqN_we/wmask/addr/din  request fields (we=1 write, 0 read)
//   rspN_valid/rdata        read response for requester N
//   sram_we/wmask/addr/din  to macro
//   sram_dout               from macro
//   busy                    high while not accepting requests (reset/scrub)
//   state_dbg               current FSM state encoding
module sram_port_arbiter #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 2,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_we,
    input  logic [WMASK_WIDTH-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0]  req0_din,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_we,
    input  logic [WMASK_WIDTH-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0]  req1_din,
    output logic                   rsp0_valid,
    output logic [DATA_WIDTH-1:0]  rsp0_rdata,
    output logic                   rsp1_valid,
    output logic [DATA_WIDTH-1:0]  rsp1_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    // ST_RESET is the one cycle following a sampled reset; it exists so the
    // outputs are quiet for that cycle regardless of what comes next.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
`ifdef SRAM_ARB_SCRUB_EN
        ST_SCRUB = 2'd1,
`endif
        ST_RUN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  rr_ptr;     // 0 favours req0, 1 favours req1
    logic                  gnt0, gnt1;
    logic                  run;
    logic [ADDR_WIDTH-1:0] addr_q;     // last address driven to the macro
    logic [DATA_WIDTH-1:0] din_q;      // last data driven to the macro
    logic                  pend0, pend1;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

`ifdef SRAM_ARB_SCRUB_EN
    localparam logic [ADDR_WIDTH:0] SCRUB_LAST = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
    logic [ADDR_WIDTH:0] scrub_cnt;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_RESET;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef SRAM_ARB_SCRUB_EN
            ST_RESET: state_nxt = ST_SCRUB;
            ST_SCRUB: if (scrub_cnt == SCRUB_LAST) state_nxt = ST_RUN;
`else
            ST_RESET: state_nxt = ST_RUN;
`endif
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_RESET;
        endcase
    end

`ifdef SRAM_ARB_SCRUB_EN
    // Counter is held at 0 outside SCRUB so a reset mid-scrub restarts at 0.
    always_ff @(posedge clock) begin
        if (!reset_n || state != ST_SCRUB) scrub_cnt <= '0;
        else                               scrub_cnt <= scrub_cnt + 1'b1;
    end
`endif

    // ---------------- arbitration ----------------
    assign run  = (state == ST_RUN);
    assign gnt0 = run && req0_valid && (!req1_valid || !rr_ptr);
    assign gnt1 = run && req1_valid && (!req0_valid ||  rr_ptr);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // After any grant, favour the requester that was not served.
    always_ff @(posedge clock) begin
        if (!reset_n)  rr_ptr <= 1'b0;
        else if (gnt0) rr_ptr <= 1'b1;
        else if (gnt1) rr_ptr <= 1'b0;
    end

    // ---------------- macro pins ----------------
    always_comb begin
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = addr_q;
        sram_din   = din_q;
        if (gnt0) begin
            sram_we    = req0_we;
            sram_wmask = req0_we ? req0_wmask : '0;
            sram_addr  = req0_addr;
            sram_din   = req0_din;
        end else if (gnt1) begin
            sram_we    = req1_we;
            sram_wmask = req1_we ? req1_wmask : '0;
            sram_addr  = req1_addr;
            sram_din   = req1_din;
        end
`ifdef SRAM_ARB_SCRUB_EN
        if (state == ST_SCRUB) begin
            sram_we    = 1'b1;
            sram_wmask = '1;
            sram_addr  = scrub_cnt[ADDR_WIDTH-1:0];
            sram_din   = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= sram_addr;
            din_q  <= sram_din;
        end
    end

    // ---------------- read responses ----------------
    // The macro presents read data the cycle after it samples the address,
    // so a one-cycle pending flag per requester steers sram_dout back.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            pend0 <= gnt0 && !req0_we;
            pend1 <= gnt1 && !req1_we;
            if (pend0) rdata0_q <= sram_dout;
            if (pend1) rdata1_q <= sram_dout;
        end
    end

    assign rsp0_valid = pend0;
    assign rsp1_valid = pend1;
    assign rsp0_rdata = pend0 ? sram_dout : rdata0_q;
    assign rsp1_rdata = pend1 ? sram_dout : rdata1_q;

    assign busy      = !run;
    assign state_dbg = state;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: behavioural model of the 64x4 macro plus
// directed scenario tasks with hand-computed expectations.
module tb_sram_port_arbiter;

    logic       clock;
    logic       reset_n;
    logic       req0_valid, req0_ready, req0_we;
    logic [1:0] req0_wmask;
    logic [5:0] req0_addr;
    logic [3:0] req0_din;
    logic       req1_valid, req1_ready, req1_we;
    logic [1:0] req1_wmask;
    logic [5:0] req1_addr;
    logic [3:0] req1_din;
    logic       rsp0_valid, rsp1_valid;
    logic [3:0] rsp0_rdata, rsp1_rdata;
    logic       sram_we;
    logic [1:0] sram_wmask;
    logic [5:0] sram_addr;
    logic [3:0] sram_din;
    logic [3:0] sram_dout;
    logic       busy;
    logic [1:0] state_dbg;

    int n_cmp;
    int n_fail;

    sram_port_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_din(req0_din),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_din(req1_din),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- macro model: masked write, registered read ----------------
    logic [3:0] mem [0:63];
    always @(posedge clock) begin
        if (sram_we)
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b/2]) mem[sram_addr][b] <= sram_din[b];
        sram_dout <= mem[sram_addr];
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic we, input logic [1:0] m,
                            input logic [5:0] a, input logic [3:0] d);
        req0_valid = v; req0_we = we; req0_wmask = m; req0_addr = a; req0_din = d;
    endtask

    task automatic set_req1(input logic v, input logic we, input logic [1:0] m,
                            input logic [5:0] a, input logic [3:0] d);
        req1_valid = v; req1_we = we; req1_wmask = m; req1_addr = a; req1_din = d;
    endtask

    task automatic do_reset;
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        set_req1(0, 0, 2'b00, 6'd0, 4'h0);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
        for (int k = 0; k < 200 && busy; k++) tick;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: busy=%b want 0", busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        set_req0(1, 1, 2'b11, 6'd7, 4'h5);
        set_req1(1, 0, 2'b11, 6'd8, 4'h3);
        reset_n = 1'b0;
        tick;
        tick;
        n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp0: got %b want 0", rsp0_valid); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp1: got %b want 0", rsp1_valid); end
        n_cmp++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", sram_we); end
        n_cmp++; if (sram_wmask !== 2'b00) begin n_fail++; $display("FAIL rst_wmask: got %b want 00", sram_wmask); end
        n_cmp++; if (sram_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", sram_addr); end
        n_cmp++; if (sram_din !== 4'h0) begin n_fail++; $display("FAIL rst_din: got %h want 0", sram_din); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        set_req1(0, 0, 2'b00, 6'd0, 4'h0);
        reset_n = 1'b1;
    endtask

    task automatic test_write_read;
        do_reset;
        set_req0(1, 1, 2'b11, 6'd5, 4'hA);
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready0: got %b want 1", req0_ready); end
        n_cmp++; if ({sram_we, sram_wmask, sram_addr, sram_din} !== {1'b1, 2'b11, 6'd5, 4'hA}) begin
            n_fail++; $display("FAIL wr_pins: got we=%b m=%b a=%0d d=%h want 1 11 5 a", sram_we, sram_wmask, sram_addr, sram_din); end
        tick;
        set_req0(1, 0, 2'b11, 6'd5, 4'h0);
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready0: got %b want 1", req0_ready); end
        n_cmp++; if ({sram_we, sram_wmask} !== 3'b000) begin
            n_fail++; $display("FAIL rd_pins: got we=%b m=%b want 0 00", sram_we, sram_wmask); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", rsp0_valid); end
        tick;
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        #1;
        n_cmp++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp0: got %b want 1", rsp0_valid); end
        n_cmp++; if (rsp0_rdata !== 4'hA) begin n_fail++; $display("FAIL rd_data0: got %h want a", rsp0_rdata); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp1: got %b want 0", rsp1_valid); end
        n_cmp++; if (sram_addr !== 6'd5) begin n_fail++; $display("FAIL idle_addr_hold: got %0d want 5", sram_addr); end
        tick;
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rsp0_one_shot: got %b want 0", rsp0_valid); end
        n_cmp++; if (rsp0_rdata !== 4'hA) begin n_fail++; $display("FAIL rdata0_hold: got %h want a", rsp0_rdata); end
    endtask

    // Both requesters valid every cycle; each works through its own list.
    logic       t_we0 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] t_a0  [4] = '{6'd20, 6'd22, 6'd20, 6'd22};
    logic [3:0] t_d0  [4] = '{4'h6, 4'h3, 4'h0, 4'h0};
    logic [3:0] t_e0  [4] = '{4'h0, 4'h0, 4'h6, 4'h3};
    logic       t_we1 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] t_a1  [4] = '{6'd21, 6'd23, 6'd21, 6'd23};
    logic [3:0] t_d1  [4] = '{4'h9, 4'hC, 4'h0, 4'h0};
    logic [3:0] t_e1  [4] = '{4'h0, 4'h0, 4'h9, 4'hC};
    logic       t_gnt [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic test_back_to_back;
        int i0, i1;
        logic pv0, pv1;
        logic [3:0] pe0, pe1;
        do_reset;
        i0 = 0; i1 = 0; pv0 = 0; pv1 = 0; pe0 = 0; pe1 = 0;
        for (int c = 0; c < 9; c++) begin
            if (i0 < 4) set_req0(1, t_we0[i0], 2'b11, t_a0[i0], t_d0[i0]);
            else        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
            if (i1 < 4) set_req1(1, t_we1[i1], 2'b11, t_a1[i1], t_d1[i1]);
            else        set_req1(0, 0, 2'b00, 6'd0, 4'h0);
            #1;
            if (c < 8) begin
                n_cmp++;
                if ({req0_ready, req1_ready} !== {!t_gnt[c], t_gnt[c]}) begin
                    n_fail++; $display("FAIL b2b_grant c=%0d: got r0=%b r1=%b want grant %0d", c, req0_ready, req1_ready, t_gnt[c]); end
            end
            n_cmp++;
            if (rsp0_valid !== pv0 || (pv0 && rsp0_rdata !== pe0)) begin
                n_fail++; $display("FAIL b2b_rsp0 c=%0d: got v=%b d=%h want v=%b d=%h", c, rsp0_valid, rsp0_rdata, pv0, pe0); end
            n_cmp++;
            if (rsp1_valid !== pv1 || (pv1 && rsp1_rdata !== pe1)) begin
                n_fail++; $display("FAIL b2b_rsp1 c=%0d: got v=%b d=%h want v=%b d=%h", c, rsp1_valid, rsp1_rdata, pv1, pe1); end
            pv0 = 0; pv1 = 0;
            if (c < 8) begin
                if (t_gnt[c] == 1'b0) begin
                    pv0 = !t_we0[i0]; pe0 = t_e0[i0]; i0++;
                end else begin
                    pv1 = !t_we1[i1]; pe1 = t_e1[i1]; i1++;
                end
            end
            tick;
        end
    endtask

    task automatic test_partial_mask;
        do_reset;
        set_req0(1, 1, 2'b11, 6'd9, 4'hF);
        tick;
        set_req0(1, 1, 2'b01, 6'd9, 4'h0);
        tick;
        set_req0(1, 0, 2'b11, 6'd9, 4'h0);
        tick;
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        #1;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 4'b1100) begin
            n_fail++; $display("FAIL partial_mask: got v=%b d=%b want v=1 d=1100", rsp0_valid, rsp0_rdata); end
    endtask

    task automatic test_reset_mid_read;
        do_reset;
        set_req0(1, 0, 2'b00, 6'd5, 4'h0);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got %b want 1", req0_ready); end
        tick;
        set_req1(1, 0, 2'b00, 6'd6, 4'h0);
        #1;
        n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL mid_rsp_drop: got %b%b want 00", rsp0_valid, rsp1_valid); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL mid_ready: got %b%b want 00", req0_ready, req1_ready); end
        reset_n = 1'b1;
        tick;
        for (int k = 0; k < 200 && busy; k++) tick;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL mid_ptr_req0: got %b%b want 10", req0_ready, req1_ready); end
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        set_req1(0, 0, 2'b00, 6'd0, 4'h0);
        tick;
    endtask

    task automatic test_hold;
        do_reset;
        set_req1(1, 1, 2'b11, 6'd40, 4'h5);
        tick;
        set_req0(1, 0, 2'b00, 6'd40, 4'h0);
        set_req1(1, 0, 2'b00, 6'd40, 4'h0);
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL hold_first: got %b%b want 10", req0_ready, req1_ready); end
        tick;
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        #1;
        n_cmp++; if (req1_ready !== 1'b1 || sram_addr !== 6'd40 || sram_we !== 1'b0) begin
            n_fail++; $display("FAIL hold_grant1: got r=%b a=%0d we=%b want 1 40 0", req1_ready, sram_addr, sram_we); end
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 4'h5 || rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_rsp0: got v0=%b d=%h v1=%b want 1 5 0", rsp0_valid, rsp0_rdata, rsp1_valid); end
        tick;
        set_req1(0, 0, 2'b00, 6'd0, 4'h0);
        #1;
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 4'h5 || rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_rsp1: got v1=%b d=%h v0=%b want 1 5 0", rsp1_valid, rsp1_rdata, rsp0_valid); end
        tick;
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL hold_one_rsp: got %b want 0", rsp1_valid); end
    endtask

`ifdef SRAM_ARB_SCRUB_EN
    task automatic test_scrub;
        int bad;
        do_reset;
        set_req0(1, 1, 2'b11, 6'd63, 4'h7);
        tick;
        set_req0(1, 0, 2'b00, 6'd63, 4'h0);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (busy !== 1'b1 || req0_ready !== 1'b0 || sram_we !== 1'b1 || sram_wmask !== 2'b11 ||
                sram_addr !== 6'(i) || sram_din !== 4'h0) bad++;
            tick;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL scrub_pins: got %0d bad cycles want 0", bad); end
        n_cmp++; if (busy !== 1'b0 || req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL scrub_exit: got busy=%b r0=%b want 0 1", busy, req0_ready); end
        tick;
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        #1;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 4'h0) begin
            n_fail++; $display("FAIL scrub_read63: got v=%b d=%h want 1 0", rsp0_valid, rsp0_rdata); end
    endtask
`endif

    // ---------------- main sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset_n = 1'b0;
        set_req0(0, 0, 2'b00, 6'd0, 4'h0);
        set_req1(0, 0, 2'b00, 6'd0, 4'h0);
        test_reset;
        test_write_read;
        test_back_to_back;
        test_partial_mask;
        test_reset_mid_read;
        test_hold;
`ifdef SRAM_ARB_SCRUB_EN
        test_scrub;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
